// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in serial-out frame serializer with ready/valid load and stallable shift
module piso_serializer #(
    parameter int   WIDTH      = 8,
    parameter int   MSB_FIRST  = 1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] din,
    output logic             load_ready,
    input  logic             shift_en,
    output logic             sout,
    output logic             sout_valid,
    output logic             last,
    output logic             done,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;
    logic             accept;
    logic             final_bit;
    assign last       = (state == SHIFT) && (cnt == CNT_LAST);
    assign final_bit  = last & shift_en;
    assign load_ready = (state == IDLE) | final_bit;
    assign accept     = load_valid & load_ready;
    assign sout_valid = (state == SHIFT);
    assign busy       = sout_valid;
    assign sout       = sout_valid ? ((MSB_FIRST != 0) ? sreg[WIDTH-1] : sreg[0]) : IDLE_LEVEL;
    // Frame control: load on accept (including back-to-back on the final bit), shift on consume, return to idle after the final bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            done <= final_bit;
            if (accept) begin
                sreg  <= din;
                cnt   <= '0;
                state <= SHIFT;
            end else if (final_bit) begin
                state <= IDLE;
            end else if (state == SHIFT && shift_en) begin
                sreg <= (MSB_FIRST != 0) ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
                cnt  <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: scoreboard bench for three serializer configurations
module tb_piso_serializer;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic a_lv = 0, a_lr, a_en = 0, a_sout, a_sv, a_last, a_done, a_busy;
    logic [3:0] a_din = '0;
    logic b_lv = 0, b_lr, b_en = 0, b_sout, b_sv, b_last, b_done, b_busy;
    logic [3:0] b_din = '0;
    logic c_lv = 0, c_lr, c_en = 0, c_sout, c_sv, c_last, c_done, c_busy;
    logic [7:0] c_din = '0;

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1), .IDLE_LEVEL(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .load_valid(a_lv), .din(a_din), .load_ready(a_lr), .shift_en(a_en),
        .sout(a_sout), .sout_valid(a_sv), .last(a_last), .done(a_done), .busy(a_busy));
    piso_serializer #(.WIDTH(4), .MSB_FIRST(0), .IDLE_LEVEL(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .load_valid(b_lv), .din(b_din), .load_ready(b_lr), .shift_en(b_en),
        .sout(b_sout), .sout_valid(b_sv), .last(b_last), .done(b_done), .busy(b_busy));
    piso_serializer #(.WIDTH(8), .MSB_FIRST(1), .IDLE_LEVEL(1'b0)) dut_c (
        .clk(clk), .rst_n(rst_n), .load_valid(c_lv), .din(c_din), .load_ready(c_lr), .shift_en(c_en),
        .sout(c_sout), .sout_valid(c_sv), .last(c_last), .done(c_done), .busy(c_busy));

    int pass_cnt = 0;
    int total_cnt = 0;
    logic qa[$];
    logic qb[$];
    logic qc[$];
    logic e;

    task automatic test_reset;
        a_en = 1; b_en = 1; c_en = 1;
        #2 rst_n = 0;
        #1;
        total_cnt++; if ({a_lr, a_sout, a_sv, a_last, a_busy, a_done} !== 6'b100000) $display("FAIL reset_async_a: got %b want 100000", {a_lr, a_sout, a_sv, a_last, a_busy, a_done}); else pass_cnt++;
        total_cnt++; if ({b_lr, b_sout, b_sv, b_last, b_busy, b_done} !== 6'b110000) $display("FAIL reset_async_b: got %b want 110000", {b_lr, b_sout, b_sv, b_last, b_busy, b_done}); else pass_cnt++;
        total_cnt++; if ({c_lr, c_sout, c_sv, c_last, c_busy, c_done} !== 6'b100000) $display("FAIL reset_async_c: got %b want 100000", {c_lr, c_sout, c_sv, c_last, c_busy, c_done}); else pass_cnt++;
        repeat (2) @(negedge clk);
        rst_n = 1;
        repeat (2) @(negedge clk);
        #1;
        total_cnt++; if ({a_lr, a_sout, a_sv, a_last, a_busy, a_done} !== 6'b100000) $display("FAIL idle_shift_en_a: got %b want 100000", {a_lr, a_sout, a_sv, a_last, a_busy, a_done}); else pass_cnt++;
        total_cnt++; if ({b_lr, b_sout, b_sv, b_last, b_busy, b_done} !== 6'b110000) $display("FAIL idle_shift_en_b: got %b want 110000", {b_lr, b_sout, b_sv, b_last, b_busy, b_done}); else pass_cnt++;
        b_en = 0; c_en = 0;
    endtask

    task automatic test_msb_first;
        @(negedge clk);
        a_din = 4'b1011; a_lv = 1;
        for (int i = 3; i >= 0; i--) qa.push_back(a_din[i]);
        #1;
        total_cnt++; if (a_lr !== 1'b1) $display("FAIL msb_ready: got %b want 1", a_lr); else pass_cnt++;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            a_lv = 0; a_din = 4'b0000;
            #1;
            total_cnt++; if (a_sv !== (k < 4)) $display("FAIL msb_valid[%0d]: got %b want %b", k, a_sv, k < 4); else pass_cnt++;
            total_cnt++; if (a_last !== (k == 3)) $display("FAIL msb_last[%0d]: got %b want %b", k, a_last, k == 3); else pass_cnt++;
            total_cnt++; if (a_done !== (k == 4)) $display("FAIL msb_done[%0d]: got %b want %b", k, a_done, k == 4); else pass_cnt++;
            if (k >= 4) begin
                total_cnt++; if (a_lr !== 1'b1 || a_sout !== 1'b0) $display("FAIL msb_idle[%0d]: got lr=%b sout=%b want lr=1 sout=0", k, a_lr, a_sout); else pass_cnt++;
            end
            if (a_sv) begin
                e = qa.size() ? qa[0] : 1'bx;
                total_cnt++; if (a_sout !== e) $display("FAIL msb_bit[%0d]: got %b want %b", k, a_sout, e); else pass_cnt++;
                if (a_en && qa.size()) void'(qa.pop_front());
            end
        end
        total_cnt++; if (qa.size() != 0) $display("FAIL msb_drain: got %0d bits left want 0", qa.size()); else pass_cnt++;
        a_en = 0;
    endtask

    task automatic test_lsb_first;
        @(negedge clk);
        b_din = 4'b1011; b_lv = 1; b_en = 1;
        for (int i = 0; i < 4; i++) qb.push_back(b_din[i]);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            b_lv = 0; b_din = 4'b0000;
            #1;
            total_cnt++; if (b_sv !== (k < 4)) $display("FAIL lsb_valid[%0d]: got %b want %b", k, b_sv, k < 4); else pass_cnt++;
            total_cnt++; if (b_done !== (k == 4)) $display("FAIL lsb_done[%0d]: got %b want %b", k, b_done, k == 4); else pass_cnt++;
            if (b_sv) begin
                e = qb.size() ? qb[0] : 1'bx;
                total_cnt++; if (b_sout !== e) $display("FAIL lsb_bit[%0d]: got %b want %b", k, b_sout, e); else pass_cnt++;
                if (b_en && qb.size()) void'(qb.pop_front());
            end else begin
                total_cnt++; if (b_sout !== 1'b1) $display("FAIL lsb_idle_level[%0d]: got %b want 1", k, b_sout); else pass_cnt++;
            end
        end
        total_cnt++; if (qb.size() != 0) $display("FAIL lsb_drain: got %0d bits left want 0", qb.size()); else pass_cnt++;
        b_en = 0;
    endtask

    task automatic test_stall;
        logic en_pat[$] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        int dones = 0;
        @(negedge clk);
        a_din = 4'b1100; a_lv = 1; a_en = 0;
        for (int i = 3; i >= 0; i--) qa.push_back(a_din[i]);
        @(negedge clk);
        a_lv = 0;
        for (int k = 0; k < 10; k++) begin
            a_en = (k < en_pat.size()) ? en_pat[k] : 1'b0;
            #1;
            if (a_done) dones++;
            total_cnt++; if (a_sv !== (k < 7)) $display("FAIL stall_valid[%0d]: got %b want %b", k, a_sv, k < 7); else pass_cnt++;
            if (a_sv) begin
                e = qa.size() ? qa[0] : 1'bx;
                total_cnt++; if (a_sout !== e) $display("FAIL stall_bit[%0d]: got %b want %b", k, a_sout, e); else pass_cnt++;
                if (a_en && qa.size()) void'(qa.pop_front());
            end
            @(negedge clk);
        end
        total_cnt++; if (qa.size() != 0 || dones != 1) $display("FAIL stall_end: got left=%0d dones=%0d want left=0 dones=1", qa.size(), dones); else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        a_en = 1; a_din = 4'b1001; a_lv = 1;
        #1;
        total_cnt++; if (a_lr !== 1'b1) $display("FAIL b2b_ready0: got %b want 1", a_lr); else pass_cnt++;
        for (int i = 3; i >= 0; i--) qa.push_back(a_din[i]);
        for (int k = 1; k < 11; k++) begin
            @(negedge clk);
            if (k == 1) a_din = 4'b0110;
            if (k == 5) begin a_lv = 0; a_din = 4'b0000; end
            #1;
            total_cnt++; if (a_sv !== (k >= 1 && k <= 8)) $display("FAIL b2b_valid[%0d]: got %b want %b", k, a_sv, k >= 1 && k <= 8); else pass_cnt++;
            total_cnt++; if (a_done !== (k == 5 || k == 9)) $display("FAIL b2b_done[%0d]: got %b want %b", k, a_done, k == 5 || k == 9); else pass_cnt++;
            total_cnt++; if (a_lr !== (k == 4 || k == 8 || k >= 9)) $display("FAIL b2b_ready[%0d]: got %b want %b", k, a_lr, k == 4 || k == 8 || k >= 9); else pass_cnt++;
            if (a_sv) begin
                e = qa.size() ? qa[0] : 1'bx;
                total_cnt++; if (a_sout !== e) $display("FAIL b2b_bit[%0d]: got %b want %b", k, a_sout, e); else pass_cnt++;
                if (a_en && qa.size()) void'(qa.pop_front());
            end
            if (k == 4) for (int i = 3; i >= 0; i--) qa.push_back(a_din[i]);
        end
        total_cnt++; if (qa.size() != 0) $display("FAIL b2b_drain: got %0d bits left want 0", qa.size()); else pass_cnt++;
        a_en = 0;
    endtask

    task automatic test_ignore_load;
        @(negedge clk);
        c_en = 1; c_din = 8'h3C; c_lv = 1;
        for (int i = 7; i >= 0; i--) qc.push_back(c_din[i]);
        for (int k = 1; k < 11; k++) begin
            @(negedge clk);
            c_lv = (k == 3);
            c_din = (k == 3) ? 8'hC3 : 8'h00;
            #1;
            total_cnt++; if (c_sv !== (k >= 1 && k <= 8)) $display("FAIL ign_valid[%0d]: got %b want %b", k, c_sv, k >= 1 && k <= 8); else pass_cnt++;
            total_cnt++; if (c_lr !== (k >= 8)) $display("FAIL ign_ready[%0d]: got %b want %b", k, c_lr, k >= 8); else pass_cnt++;
            total_cnt++; if (c_done !== (k == 9)) $display("FAIL ign_done[%0d]: got %b want %b", k, c_done, k == 9); else pass_cnt++;
            if (c_sv) begin
                e = qc.size() ? qc[0] : 1'bx;
                total_cnt++; if (c_sout !== e) $display("FAIL ign_bit[%0d]: got %b want %b", k, c_sout, e); else pass_cnt++;
                if (c_en && qc.size()) void'(qc.pop_front());
            end
        end
        total_cnt++; if (qc.size() != 0) $display("FAIL ign_drain: got %0d bits left want 0", qc.size()); else pass_cnt++;
    endtask

    task automatic test_reset_midframe;
        @(negedge clk);
        c_en = 1; c_din = 8'hA5; c_lv = 1;
        for (int i = 7; i >= 0; i--) qc.push_back(c_din[i]);
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            c_lv = 0; c_din = 8'h00;
            #1;
            e = qc.size() ? qc[0] : 1'bx;
            total_cnt++; if (c_sv !== 1'b1 || c_sout !== e) $display("FAIL rst_mid_bit[%0d]: got v=%b sout=%b want v=1 sout=%b", k, c_sv, c_sout, e); else pass_cnt++;
            if (qc.size()) void'(qc.pop_front());
        end
        @(negedge clk);
        #1;
        total_cnt++; if (c_sv !== 1'b1) $display("FAIL rst_mid_busy_before: got %b want 1", c_sv); else pass_cnt++;
        #1 rst_n = 0;
        #1;
        total_cnt++; if ({c_lr, c_sout, c_sv, c_last, c_busy, c_done} !== 6'b100000) $display("FAIL rst_mid_abort: got %b want 100000", {c_lr, c_sout, c_sv, c_last, c_busy, c_done}); else pass_cnt++;
        qc.delete();
        @(negedge clk);
        #1;
        total_cnt++; if (c_done !== 1'b0) $display("FAIL rst_mid_no_done: got %b want 0", c_done); else pass_cnt++;
        @(negedge clk);
        rst_n = 1; c_din = 8'hFF; c_lv = 1;
        for (int i = 0; i < 8; i++) qc.push_back(1'b1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            c_lv = 0; c_din = 8'h00;
            #1;
            total_cnt++; if (c_sv !== (k < 8)) $display("FAIL rst_new_valid[%0d]: got %b want %b", k, c_sv, k < 8); else pass_cnt++;
            total_cnt++; if (c_done !== (k == 8)) $display("FAIL rst_new_done[%0d]: got %b want %b", k, c_done, k == 8); else pass_cnt++;
            if (c_sv) begin
                e = qc.size() ? qc[0] : 1'bx;
                total_cnt++; if (c_sout !== e) $display("FAIL rst_new_bit[%0d]: got %b want %b", k, c_sout, e); else pass_cnt++;
                if (c_en && qc.size()) void'(qc.pop_front());
            end
        end
        total_cnt++; if (qc.size() != 0) $display("FAIL rst_new_drain: got %0d bits left want 0", qc.size()); else pass_cnt++;
        c_en = 0;
    endtask

    initial begin
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_stall();
        test_back_to_back();
        test_ignore_load();
        test_reset_midframe();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
